// File: rtl/dual_port_bytewise_ram_pkg.sv
// Shared constants and types for the OCM dual-port byte-writable RAM.
// Lane geometry matches the OCM package constants so both agree on data width.
package dual_port_bytewise_ram_pkg;
    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = BYTE_W * NUM_LANES;

    typedef logic [NUM_LANES-1:0] lane_mask_t;
endpackage

// File: rtl/dual_port_bytewise_ram_ram_port_reg.sv
// Per-port read-data register: async active-low clear, loads only when the port is enabled.
// Holding on disable gives the "dout keeps its last value" behaviour for idle ports.
module ram_port_reg
    import dual_port_bytewise_ram_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dual_port_bytewise_ram.sv
// True dual-port 32-bit RAM with per-byte write enables, read-first on both ports.
// On a same-address, same-lane write collision port A's byte is kept.
module dual_port_bytewise_ram
    import dual_port_bytewise_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  enaA,
    input  lane_mask_t            weA,
    input  logic [ADDR_WIDTH-1:0] addrA,
    input  logic [DATA_W-1:0]     dinA,
    output logic [DATA_W-1:0]     doutA,
    input  logic                  enaB,
    input  lane_mask_t            weB,
    input  logic [ADDR_WIDTH-1:0] addrB,
    input  logic [DATA_W-1:0]     dinB,
    output logic [DATA_W-1:0]     doutB
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // Port B lanes are scheduled first so a same-lane port A write overrides them.
    always_ff @(posedge clk) begin
        if (nrst) begin
            for (int lane = 0; lane < NUM_LANES; lane++) begin
                if (enaB && weB[lane]) begin
                    r_mem[addrB][lane*BYTE_W +: BYTE_W] <= dinB[lane*BYTE_W +: BYTE_W];
                end
                if (enaA && weA[lane]) begin
                    r_mem[addrA][lane*BYTE_W +: BYTE_W] <= dinA[lane*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Sampled at the same edge as the write, so readers always see pre-write data.
    assign w_rd_a = r_mem[addrA];
    assign w_rd_b = r_mem[addrB];

    ram_port_reg u_port_a (
        .clk  (clk),
        .nrst (nrst),
        .i_en (enaA),
        .i_d  (w_rd_a),
        .o_q  (doutA)
    );

    ram_port_reg u_port_b (
        .clk  (clk),
        .nrst (nrst),
        .i_en (enaB),
        .i_d  (w_rd_b),
        .o_q  (doutB)
    );

endmodule

// File: tb/tb_dual_port_bytewise_ram.sv
// Scoreboard bench for dual_port_bytewise_ram: byte-level reference memory, expected
// read data queued at drive time and compared one cycle later.
module tb_dual_port_bytewise_ram;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enaA = 1'b0;
    logic [3:0]  weA = '0;
    logic [11:0] addrA = '0;
    logic [31:0] dinA = '0;
    logic [31:0] doutA;
    logic        enaB = 1'b0;
    logic [3:0]  weB = '0;
    logic [11:0] addrB = '0;
    logic [31:0] dinB = '0;
    logic [31:0] doutB;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_mem [int];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    bit          last_a_ok = 1'b1;
    bit          last_b_ok = 1'b1;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          port_b;
    } exp_t;
    exp_t sb_q[$];

    dual_port_bytewise_ram #(.ADDR_WIDTH(12), .INIT_FILE("")) dut (
        .clk   (clk),
        .nrst  (nrst),
        .enaA  (enaA),
        .weA   (weA),
        .addrA (addrA),
        .dinA  (dinA),
        .doutA (doutA),
        .enaB  (enaB),
        .weB   (weB),
        .addrB (addrB),
        .dinB  (dinB),
        .doutB (doutB)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s: got %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] din);
        logic [31:0] v;
        v = old;
        for (int l = 0; l < 4; l++) begin
            if (we[l]) v[l*8 +: 8] = din[l*8 +: 8];
        end
        return v;
    endfunction

    // One clock of stimulus on both ports; all outstanding expectations checked after the edge.
    task automatic cycle(input string tag,
                         input bit ea, input logic [3:0] wa, input logic [11:0] aa, input logic [31:0] da,
                         input bit eb, input logic [3:0] wb, input logic [11:0] ab, input logic [31:0] db);
        logic [31:0] old_v;
        exp_t        e;
        if (ea) begin
            last_a    = m_mem.exists(int'(aa)) ? m_mem[int'(aa)] : 32'hx;
            last_a_ok = !$isunknown(last_a);
        end
        if (eb) begin
            last_b    = m_mem.exists(int'(ab)) ? m_mem[int'(ab)] : 32'hx;
            last_b_ok = !$isunknown(last_b);
        end
        if (last_a_ok) sb_q.push_back('{{tag, "/A"}, last_a, 1'b0});
        if (last_b_ok) sb_q.push_back('{{tag, "/B"}, last_b, 1'b1});
        if (eb && wb != 4'h0) begin
            old_v = m_mem.exists(int'(ab)) ? m_mem[int'(ab)] : 32'hx;
            m_mem[int'(ab)] = merge(old_v, wb, db);
        end
        if (ea && wa != 4'h0) begin
            old_v = m_mem.exists(int'(aa)) ? m_mem[int'(aa)] : 32'hx;
            m_mem[int'(aa)] = merge(old_v, wa, da);
        end
        enaA = ea; weA = wa; addrA = aa; dinA = da;
        enaB = eb; weB = wb; addrB = ab; dinB = db;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, e.port_b ? doutB : doutA, e.exp);
        end
    endtask

    initial begin
        #12;
        check_eq("reset_doutA", doutA, 32'h0);
        check_eq("reset_doutB", doutB, 32'h0);
        @(negedge clk);
        nrst = 1'b1;

        cycle("preload0", 1, 4'hF, 12'h010, 32'h11223344, 1, 4'hF, 12'h020, 32'h0);
        cycle("preload1", 1, 4'hF, 12'h006, 32'h66666666, 1, 4'hF, 12'h030, 32'h0);

        cycle("full_wr", 1, 4'hF, 12'h005, 32'hDEADBEEF, 0, 4'h0, 12'h0, 32'h0);
        cycle("full_rd", 1, 4'h0, 12'h005, 32'h0, 1, 4'h0, 12'h005, 32'h0);
        check_eq("full_A_lit", doutA, 32'hDEADBEEF);
        check_eq("full_B_lit", doutB, 32'hDEADBEEF);

        cycle("lane_wr", 1, 4'b0101, 12'h010, 32'hAABBCCDD, 0, 4'h0, 12'h0, 32'h0);
        cycle("lane_rd", 1, 4'h0, 12'h010, 32'h0, 0, 4'h0, 12'h0, 32'h0);
        check_eq("lane_lit", doutA, 32'h11BB33DD);

        cycle("rdfirst_wr", 1, 4'hF, 12'h020, 32'h12345678, 0, 4'h0, 12'h0, 32'h0);
        check_eq("rdfirst_old_lit", doutA, 32'h0);
        cycle("rdfirst_rd", 1, 4'h0, 12'h020, 32'h0, 0, 4'h0, 12'h0, 32'h0);
        check_eq("rdfirst_new_lit", doutA, 32'h12345678);

        cycle("coll_wr", 1, 4'b0011, 12'h030, 32'hAAAAAAAA, 1, 4'b0110, 12'h030, 32'hBBBBBBBB);
        cycle("coll_rd", 1, 4'h0, 12'h030, 32'h0, 1, 4'h0, 12'h030, 32'h0);
        check_eq("coll_lit", doutA, 32'h00BBAAAA);
        cycle("coll_rw", 1, 4'hF, 12'h030, 32'hCAFEF00D, 1, 4'h0, 12'h030, 32'h0);
        check_eq("coll_rw_old_lit", doutB, 32'h00BBAAAA);
        cycle("coll_rw_next", 0, 4'h0, 12'h0, 32'h0, 1, 4'h0, 12'h030, 32'h0);
        check_eq("coll_rw_new_lit", doutB, 32'hCAFEF00D);

        cycle("hold_rd", 1, 4'h0, 12'h005, 32'h0, 0, 4'h0, 12'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle("hold", 0, 4'hF, 12'h006, 32'h0BADF00D, 0, 4'h0, 12'h0, 32'h0);
            check_eq("hold_lit", doutA, 32'hDEADBEEF);
        end
        cycle("hold_mem", 1, 4'h0, 12'h006, 32'h0, 0, 4'h0, 12'h0, 32'h0);
        check_eq("hold_mem_lit", doutA, 32'h66666666);

        cycle("rst_pre", 1, 4'h0, 12'h005, 32'h0, 1, 4'h0, 12'h005, 32'h0);
        @(negedge clk);
        enaA = 1'b1; weA = 4'hF; addrA = 12'h005; dinA = 32'h0;
        #1 nrst = 1'b0;
        #1;
        check_eq("async_rst_A", doutA, 32'h0);
        check_eq("async_rst_B", doutB, 32'h0);
        @(posedge clk);
        #1;
        check_eq("rst_hold_A", doutA, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        last_a = '0; last_a_ok = 1'b1;
        last_b = '0; last_b_ok = 1'b1;
        cycle("post_rst", 1, 4'h0, 12'h005, 32'h0, 0, 4'h0, 12'h0, 32'h0);
        check_eq("post_rst_lit", doutA, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) begin
            cycle("rand_init", 1, 4'hF, 12'(12'h040 + i), $urandom, 0, 4'h0, 12'h0, 32'h0);
        end
        for (int i = 0; i < 60; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  12'(12'h040 + $urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  12'(12'h040 + $urandom_range(0, 7)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
